operand_fwd_mux: RTL and testbench

Parametrised N-input operand forwarding multiplexer with stall-capture, for the EX-stage operand path of the pipelined core. Selects one of NUM_IN forwarding sources (register file, EX/MEM, MEM/WB, multi-cycle multiplier result, ...). On a pipeline stall it captures the selected value. This keeps the operand stable while the forwarding source retires during multi-cycle operations such as the 4-cycle multiplier. It also flags out-of-range select codes.

---
 rtl/operand_fwd_mux.sv | 90 +++++++++
 tb/tb_operand_fwd_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_fwd_mux.sv
// Purpose: N-way EX-stage operand forwarding mux that freezes the selected operand while the stage stalls.
// Latency: 0 cycles select/in_data -> out_data when live; a captured operand appears the cycle after the first stall edge.
// Backpressure: stall freezes the operand (first stall edge captures, later stall edges hold); flush drops any capture.
module operand_fwd_mux #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         select,
    input  logic                     stall,
    input  logic                     flush,
    output logic [DATA_W-1:0]        out_data,
    output logic                     held,
    output logic                     sel_err
);

    // One-bit state: LIVE passes the mux through, HOLD replays the capture register.
    localparam logic [0:0] ST_LIVE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Highest legal select code; unused codes fall back to this source.
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

    logic [DATA_W-1:0] src [NUM_IN];
    logic [DATA_W-1:0] mux_v;
    logic [DATA_W-1:0] hold_q;
    logic [0:0]        hold_vld;
    logic              sel_oob;

    // Split the packed source bus into one word per forwarding source.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_src
        assign src[k] = in_data[k*DATA_W +: DATA_W];
    end

    // Out-of-range codes only exist when the select field has spare encodings.
    if (NUM_IN < (2 ** SEL_W)) begin : g_oob
        assign sel_oob = (select > LAST_SEL);
    end else begin : g_no_oob
        assign sel_oob = 1'b0;
    end

    // Live source select; the last source doubles as the default for every unused code.
    always_comb begin
        mux_v = src[NUM_IN-1];
        for (int k = 0; k < NUM_IN - 1; k++) begin
            if (select == SEL_W'(k)) begin
                mux_v = src[k];
            end
        end
    end

    // Capture/hold state: flush beats stall, the first stall edge captures, release returns to live.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            hold_vld <= ST_LIVE;
        end else if (flush) begin
            hold_q   <= '0;
            hold_vld <= ST_LIVE;
        end else if (stall) begin
            if (hold_vld == ST_LIVE) begin
                hold_q   <= mux_v;
                hold_vld <= ST_HOLD;
            end
        end else begin
            // hold_q keeps its stale value; it is not visible while live.
            hold_vld <= ST_LIVE;
        end
    end

    // Sticky bad-select flag; a select seen while holding is not in use, so it is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if ((hold_vld == ST_LIVE) && sel_oob) begin
            sel_err <= 1'b1;
        end
    end

    // Output steering: captured value while holding, live mux otherwise.
    always_comb begin
        out_data = (hold_vld == ST_HOLD) ? hold_q : mux_v;
    end

    assign held = hold_vld[0];

endmodule

// File: tb/tb_operand_fwd_mux.sv
// Purpose: directed self-checking bench for operand_fwd_mux (4-source and 3-source builds).
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: stall/flush sequences exercise capture, hold, release, flush priority and reset.
module tb_operand_fwd_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-source build: every select code is legal.
    logic        rst4;
    logic [63:0] in4;
    logic [1:0]  sel4;
    logic        stall4, flush4;
    logic [15:0] out4;
    logic        held4, err4;

    // 3-source build: select code 3 is out of range.
    logic        rst3;
    logic [47:0] in3;
    logic [1:0]  sel3;
    logic        stall3, flush3;
    logic [15:0] out3;
    logic        held3, err3;

    int checks = 0;
    int errors = 0;

    operand_fwd_mux #(.DATA_W(16), .NUM_IN(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .rst(rst4), .in_data(in4), .select(sel4),
        .stall(stall4), .flush(flush4),
        .out_data(out4), .held(held4), .sel_err(err4)
    );

    operand_fwd_mux #(.DATA_W(16), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst(rst3), .in_data(in3), .select(sel3),
        .stall(stall3), .flush(flush3),
        .out_data(out3), .held(held3), .sel_err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sweep_exp [4];

    initial begin
        sweep_exp[0] = 16'h1111;
        sweep_exp[1] = 16'h2222;
        sweep_exp[2] = 16'h3333;
        sweep_exp[3] = 16'h4444;

        rst4 = 1'b1; sel4 = 2'd0; stall4 = 1'b0; flush4 = 1'b0;
        in4  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        rst3 = 1'b1; sel3 = 2'd0; stall3 = 1'b0; flush3 = 1'b0;
        in3  = {16'h3333, 16'h2222, 16'h1111};
        tick();
        tick();

        // ---- reset state, 4-source build
        rst4 = 1'b0;
        #1;
        chk("rst_held", {31'd0, held4}, 32'd0);
        chk("rst_err",  {31'd0, err4},  32'd0);
        chk("rst_out",  {16'd0, out4},  32'h1111);

        // ---- live sweep: out tracks select within the same cycle
        for (int s = 0; s < 4; s++) begin
            sel4 = 2'(s);
            #1;
            chk($sformatf("live_sel%0d", s), {16'd0, out4}, {16'd0, sweep_exp[s]});
            chk($sformatf("live_held%0d", s), {31'd0, held4}, 32'd0);
            tick();
            chk($sformatf("live_err%0d", s), {31'd0, err4}, 32'd0);
        end

        // ---- stall capture: stall high for 4 cycles, source 2 changes during hold
        sel4 = 2'd2; stall4 = 1'b1;
        #1;
        chk("cap_c1_out",  {16'd0, out4},  32'h3333);
        chk("cap_c1_held", {31'd0, held4}, 32'd0);
        tick();
        in4[47:32] = 16'hBEEF;
        #1;
        chk("cap_c2_out",  {16'd0, out4},  32'h3333);
        chk("cap_c2_held", {31'd0, held4}, 32'd1);
        tick();
        chk("cap_c3_out",  {16'd0, out4},  32'h3333);
        tick();
        chk("cap_c4_out",  {16'd0, out4},  32'h3333);
        chk("cap_c4_held", {31'd0, held4}, 32'd1);
        tick();
        stall4 = 1'b0;
        #1;
        chk("rel_c5_out",  {16'd0, out4},  32'h3333);
        tick();
        chk("rel_out",  {16'd0, out4},  32'hBEEF);
        chk("rel_held", {31'd0, held4}, 32'd0);

        // ---- single-cycle stall pulse gives exactly one hold cycle
        in4[47:32] = 16'h3333;
        stall4 = 1'b1;
        tick();
        stall4 = 1'b0;
        in4[47:32] = 16'h2468;
        #1;
        chk("pulse_hold_out", {16'd0, out4}, 32'h3333);
        tick();
        chk("pulse_live_out", {16'd0, out4}, 32'h2468);
        chk("pulse_live_held", {31'd0, held4}, 32'd0);

        // ---- flush priority over stall while holding 0x3333
        in4[47:32] = 16'h3333;
        stall4 = 1'b1;
        tick();
        chk("fl_hold_out", {16'd0, out4}, 32'h3333);
        in4[47:32] = 16'h5A5A;
        flush4 = 1'b1;
        tick();
        chk("fl_held", {31'd0, held4}, 32'd0);
        chk("fl_out",  {16'd0, out4},  32'h5A5A);
        flush4 = 1'b0;
        in4[47:32] = 16'h6B6B;
        #1;
        chk("fl_live_out", {16'd0, out4}, 32'h6B6B);
        tick();
        chk("fl_recap_held", {31'd0, held4}, 32'd1);
        in4[47:32] = 16'h7777;
        #1;
        chk("fl_recap_out", {16'd0, out4}, 32'h6B6B);
        stall4 = 1'b0;
        tick();
        chk("fl_rel_out", {16'd0, out4}, 32'h7777);
        in4[47:32] = 16'h3333;

        // ---- reset mid-hold, stall kept high, then recapture
        sel4 = 2'd3; stall4 = 1'b1;
        tick();
        chk("rh_hold_out",  {16'd0, out4},  32'h4444);
        chk("rh_hold_held", {31'd0, held4}, 32'd1);
        rst4 = 1'b1;
        tick();
        chk("rh_rst_held", {31'd0, held4}, 32'd0);
        chk("rh_rst_err",  {31'd0, err4},  32'd0);
        chk("rh_rst_out",  {16'd0, out4},  32'h4444);
        rst4 = 1'b0;
        in4[63:48] = 16'h9999;
        tick();
        chk("rh_recap_held", {31'd0, held4}, 32'd1);
        in4[63:48] = 16'h1234;
        #1;
        chk("rh_recap_out", {16'd0, out4}, 32'h9999);
        stall4 = 1'b0;
        tick();
        chk("rh_rel_out", {16'd0, out4}, 32'h1234);
        chk("err4_never", {31'd0, err4}, 32'd0);

        // ---- 3-source build: out-of-range select defaults to source 2
        rst3 = 1'b0;
        #1;
        chk("n3_rst_err", {31'd0, err3}, 32'd0);
        sel3 = 2'd3;
        #1;
        chk("n3_oob_out",    {16'd0, out3}, 32'h3333);
        chk("n3_oob_err_c0", {31'd0, err3}, 32'd0);
        tick();
        chk("n3_oob_err", {31'd0, err3}, 32'd1);
        sel3 = 2'd0;
        #1;
        chk("n3_back_out", {16'd0, out3}, 32'h1111);
        tick();
        tick();
        chk("n3_sticky", {31'd0, err3}, 32'd1);
        rst3 = 1'b1;
        tick();
        chk("n3_rst_clr", {31'd0, err3}, 32'd0);
        rst3 = 1'b0;

        // ---- 3-source build: out-of-range select only while holding is ignored
        stall3 = 1'b1;
        tick();
        chk("n3_hold_held", {31'd0, held3}, 32'd1);
        sel3 = 2'd3;
        tick();
        chk("n3_hold_out", {16'd0, out3}, 32'h1111);
        tick();
        chk("n3_hold_err", {31'd0, err3}, 32'd0);
        sel3 = 2'd0; stall3 = 1'b0;
        tick();
        chk("n3_rel_err",  {31'd0, err3},  32'd0);
        chk("n3_rel_held", {31'd0, held3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
